// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between instruction fetch and
//            the load/store stage. Data has fixed priority over fetch.
//            Generates byte strobes and lane-replicated store data, returns
//            lane-shifted load data, rejects misaligned data accesses and
//            aborts accesses the memory never acknowledges.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // load/store stage
  input  logic        d_req,
  input  logic [4:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] tcnt;
  logic [1:0]    d_off;

  logic [1:0]  d_size;
  logic [1:0]  off;
  logic        d_illegal;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;

  // sign/unsigned flag, reserved op bit and fetch byte offset are not used here
  logic unused_bits;
  assign unused_bits = ^{d_op[4], d_op[2], if_addr[1:0]};

  assign d_size = d_op[1:0];
  assign off    = d_addr[1:0];

  // Alignment check plus strobe/data lane placement for the pending data request
  always_comb begin
    d_illegal = 1'b0;
    lane_strb = 4'b1111;
    lane_data = d_wdata;
    case (d_size)
      2'b00: begin
        lane_strb = 4'b0001 << off;
        lane_data = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        d_illegal = off[0];
        lane_strb = 4'b0011 << off;
        lane_data = {2{d_wdata[15:0]}};
      end
      2'b10: begin
        d_illegal = (off != 2'b00);
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
  end

  // Request sequencing, memory port drive, timeout and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      d_off     <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= 32'h0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 32'h0;
    end else begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (d_req) begin
            d_off <= off;
            if (d_illegal) begin
              // rejected without touching the memory
              state  <= RESP;
              d_done <= 1'b1;
              d_err  <= 1'b1;
            end else begin
              state     <= BUSY_D;
              mem_req   <= 1'b1;
              mem_we    <= d_op[3];
              mem_wstrb <= d_op[3] ? lane_strb : 4'b0000;
              mem_addr  <= {d_addr[31:2], 2'b00};
              mem_wdata <= lane_data;
            end
          end else if (if_req) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_addr  <= {if_addr[31:2], 2'b00};
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready || (tcnt == LAST)) begin
            // completion has priority over abort on the final cycle
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (state == BUSY_I) begin
              if_done <= 1'b1;
              if_err  <= ~mem_ready;
              if (mem_ready) if_rdata <= mem_rdata;
            end else begin
              d_done <= 1'b1;
              d_err  <= ~mem_ready;
              if (mem_ready) d_rdata <= mem_rdata >> {d_off, 3'b000};
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          // RESP: requests are not sampled during the done cycle
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter. Stimulus pushes expected
//            memory transactions and requester responses into queues; a
//            memory responder and a response monitor pop and compare.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk, rst_n;
  logic        if_req, if_done, if_err, d_req, d_done, d_err;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [4:0]  d_op;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          start;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] word;
    int          waits;
  } memx_t;

  resp_t sb[$];
  memx_t memq[$];
  int    vectors = 0;
  int    fails   = 0;
  int    cyc     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // store data as seen on the bus: every lane carries byte (lane mod access size)
  function automatic logic [31:0] lanes(input int n, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  // memory responder: checks each access as it starts and its request duration as it ends
  initial begin : memory
    memx_t cur;
    int    cnt, hi, want;
    bit    active;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    active    = 1'b0;
    cnt = 0; hi = 0;
    cur = '{addr: 0, we: 0, wstrb: 0, wdata: 0, word: 0, waits: 1000};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ready = 1'b0;
        active    = 1'b0;
      end else begin
        if (mem_req && !active) begin
          active = 1'b1; cnt = 0; hi = 0;
          vectors++;
          if (memq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_mem_access: got addr=%h, want no access", mem_addr);
            cur = '{addr: 0, we: 0, wstrb: 0, wdata: 0, word: 0, waits: 1000};
          end else begin
            cur = memq.pop_front();
            if ({mem_addr, mem_we, mem_wstrb} !== {cur.addr, cur.we, cur.wstrb}) begin
              fails++;
              $display("FAIL mem_cmd: got addr=%h we=%b strb=%b, want addr=%h we=%b strb=%b",
                       mem_addr, mem_we, mem_wstrb, cur.addr, cur.we, cur.wstrb);
            end
            if (cur.we) begin
              vectors++;
              if (mem_wdata !== cur.wdata) begin
                fails++;
                $display("FAIL mem_wdata: got %h, want %h", mem_wdata, cur.wdata);
              end
            end
          end
        end
        if (active) begin
          if (mem_req) begin
            hi++;
            if (cnt == cur.waits) begin
              mem_ready = 1'b1;
              mem_rdata = cur.word;
            end else begin
              mem_ready = 1'b0;
              mem_rdata = $urandom;
            end
            cnt++;
          end else begin
            active    = 1'b0;
            mem_ready = 1'b0;
            want = (cur.waits >= TIMEOUT) ? TIMEOUT : cur.waits + 1;
            vectors++;
            if (hi != want) begin
              fails++;
              $display("FAIL mem_req_cycles: got %0d, want %0d", hi, want);
            end
          end
        end
      end
    end
  end

  // response monitor: every done pulse must match the next expected response
  initial begin : monitor
    resp_t e;
    logic  got_err;
    logic [31:0] got_rd;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((if_err && !if_done) || (d_err && !d_done)) begin
          vectors++; fails++;
          $display("FAIL err_without_done: got if_err=%b d_err=%b with if_done=%b d_done=%b",
                   if_err, d_err, if_done, d_done);
        end
        if (if_done || d_done) begin
          vectors++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: got if_done=%b d_done=%b, want none", if_done, d_done);
          end else begin
            e = sb.pop_front();
            got_err = e.is_d ? d_err : if_err;
            got_rd  = e.is_d ? d_rdata : if_rdata;
            if ({d_done, if_done, got_err} !== {e.is_d, ~e.is_d, e.err} || (cyc - e.start) != e.lat) begin
              fails++;
              $display("FAIL resp: got d_done=%b if_done=%b err=%b lat=%0d, want d_done=%b if_done=%b err=%b lat=%0d",
                       d_done, if_done, got_err, cyc - e.start, e.is_d, ~e.is_d, e.err, e.lat);
            end
            if (!e.err) begin
              vectors++;
              if (got_rd !== e.rdata) begin
                fails++;
                $display("FAIL rdata: got %h, want %h", got_rd, e.rdata);
              end
            end
          end
        end
      end
    end
  end

  // Present a data and/or fetch request, queue their expectations, and hold each until done.
  task automatic issue(input bit do_d, input logic [4:0] op, input logic [31:0] da,
                       input logic [31:0] dw, input logic [31:0] dword, input int dwait,
                       input bit do_i, input logic [31:0] ia, input logic [31:0] iword,
                       input int iwait);
    int  n, off, dlat, ilat;
    bit  legal;
    dlat = 0;
    @(negedge clk);
    if (do_d) begin
      n     = 1 << op[1:0];
      off   = int'(da[1:0]);
      legal = (op[1:0] != 2'b11) && (off % n == 0);
      if (legal)
        memq.push_back('{addr: da & ~32'h3, we: op[3],
                         wstrb: op[3] ? 4'(((1 << n) - 1) << off) : 4'b0000,
                         wdata: lanes(n, dw), word: dword, waits: dwait});
      dlat = !legal ? 1 : (dwait >= TIMEOUT ? TIMEOUT + 1 : dwait + 2);
      sb.push_back('{is_d: 1'b1, err: !legal || dwait >= TIMEOUT,
                     rdata: dword >> (8 * off), lat: dlat, start: cyc});
    end
    if (do_i) begin
      ilat = (iwait >= TIMEOUT ? TIMEOUT + 1 : iwait + 2) + (do_d ? dlat + 1 : 0);
      memq.push_back('{addr: ia & ~32'h3, we: 1'b0, wstrb: 4'b0000, wdata: 32'h0,
                       word: iword, waits: iwait});
      sb.push_back('{is_d: 1'b0, err: iwait >= TIMEOUT, rdata: iword, lat: ilat, start: cyc});
    end
    d_req = do_d; d_op = op; d_addr = da; d_wdata = dw;
    if_req = do_i; if_addr = ia;
    for (int k = 0; k < 300 && (d_req || if_req); k++) begin
      @(negedge clk);
      if (d_done) d_req = 1'b0;
      if (if_done) if_req = 1'b0;
    end
    if (d_req || if_req) begin
      vectors++; fails++;
      $display("FAIL done_timeout: got d_req=%b if_req=%b still pending, want both served", d_req, if_req);
      d_req = 1'b0; if_req = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, if_done, d_done, if_err, d_err,
         if_rdata, d_rdata} !== '0) begin
      fails++;
      $display("FAIL %s: got mem_req=%b we=%b strb=%b addr=%h wdata=%h done=%b/%b err=%b/%b rd=%h/%h, want all 0",
               tag, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, if_done, d_done,
               if_err, d_err, if_rdata, d_rdata);
    end
  endtask

  initial begin : stimulus
    int r, w;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_op = 5'h0; d_addr = 32'h0; d_wdata = 32'h0;
    #1 check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // zero-wait fetch
    issue(0, 5'h00, 0, 0, 0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    // simultaneous requests: data load word first, fetch 3 cycles after
    issue(1, 5'b00010, 32'h200, 0, 32'hCAFE_F00D, 0, 1, 32'h0000_0107, 32'h1357_9BDF, 0);
    // store byte at lane 3, store half at lane 2
    issue(1, 5'b01000, 32'h203, 32'h0000_00AB, 0, 0, 0, 0, 0, 0);
    issue(1, 5'b01001, 32'h202, 32'h0000_1234, 0, 1, 0, 0, 0, 0);
    // load byte at offset 1 with 3 wait cycles
    issue(1, 5'b00100, 32'h201, 0, 32'h1122_3344, 3, 0, 0, 0, 0);
    // misaligned word, illegal size, misaligned half
    issue(1, 5'b00010, 32'h202, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 5'b00011, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 5'b01001, 32'h301, 32'hFFFF, 0, 0, 0, 0, 0, 0);
    // last-chance acknowledge, then data and fetch timeouts
    issue(0, 5'h00, 0, 0, 0, 0, 1, 32'h0000_0400, 32'hA5A5_5A5A, TIMEOUT - 1);
    issue(1, 5'b00010, 32'h404, 0, 32'h1, TIMEOUT + 5, 0, 0, 0, 0);
    issue(0, 5'h00, 0, 0, 0, 0, 1, 32'h0000_0408, 32'h2, TIMEOUT + 5);

    // reset asserted in the middle of a data access
    @(negedge clk);
    memq.push_back('{addr: 32'h500, we: 1'b0, wstrb: 4'b0000, wdata: 32'h0, word: 32'h0, waits: 1000});
    d_req = 1'b1; d_op = 5'b00010; d_addr = 32'h500;
    repeat (4) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL busy_before_reset: got mem_req=%b, want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 2);
      w = ($urandom_range(0, 9) == 9) ? TIMEOUT + 3 : $urandom_range(0, 3);
      issue(r != 1, 5'($urandom), $urandom, $urandom, $urandom, w,
            r != 0, $urandom, $urandom, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    vectors++;
    if (sb.size() != 0 || memq.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d responses and %0d accesses outstanding, want 0/0",
               sb.size(), memq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
